pcie_us_cfg_mgmt_arb: RTL and testbench

- Round-robin arbiter that shares the single UltraScale PCIe hard-block configuration management port (cfg_mgmt_*) between PORTS requesters, e.g. a host-visible config bridge and on-chip init logic.
- Sits between the requester logic in the core and the cfg_mgmt pins of the PCIe IP.
- Serialises accesses with exactly one access outstanding at a time.
- Returns read data and the completion to the requester that owns the access.

---
 rtl/pcie_us_cfg_mgmt_arb.sv | 222 ++++++++++++++++++++++
 tb/tb_pcie_us_cfg_mgmt_arb.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_us_cfg_mgmt_arb.sv
// rtl/pcie_us_cfg_mgmt_arb.sv - round-robin arbiter sharing the UltraScale PCIe cfg_mgmt port
// Optional access abort timer: define PCIE_CFG_MGMT_ARB_TIMEOUT_EN.
module pcie_us_cfg_mgmt_arb #(
  parameter int PORTS          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORTS*10-1:0]   s_cfg_mgmt_addr,
  input  logic [PORTS*8-1:0]    s_cfg_mgmt_function_number,
  input  logic [PORTS-1:0]      s_cfg_mgmt_write,
  input  logic [PORTS*32-1:0]   s_cfg_mgmt_write_data,
  input  logic [PORTS*4-1:0]    s_cfg_mgmt_byte_enable,
  input  logic [PORTS-1:0]      s_cfg_mgmt_read,
  output logic [31:0]           s_cfg_mgmt_read_data,
  output logic [PORTS-1:0]      s_cfg_mgmt_read_write_done,
  output logic [PORTS-1:0]      s_cfg_mgmt_timeout,
  output logic [9:0]            cfg_mgmt_addr,
  output logic [7:0]            cfg_mgmt_function_number,
  output logic                  cfg_mgmt_write,
  output logic [31:0]           cfg_mgmt_write_data,
  output logic [3:0]            cfg_mgmt_byte_enable,
  output logic                  cfg_mgmt_read,
  input  logic [31:0]           cfg_mgmt_read_data,
  input  logic                  cfg_mgmt_read_write_done
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  if (PORTS < 1 || PORTS > 8) begin : g_bad_ports
    $error("pcie_us_cfg_mgmt_arb: PORTS must be 1..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("pcie_us_cfg_mgmt_arb: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, GUARD} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [9:0]       addr_q, addr_d;
  logic [7:0]       fn_q, fn_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [PORTS-1:0] done_q, done_d;
  logic [PORTS-1:0] tmo_q, tmo_d;

  logic [PORTS-1:0] req;
  logic [PW-1:0]    pick, pick_hi, pick_lo;
  logic             found_hi;
  logic [PORTS-1:0] gnt_oh;
  logic [9:0]       addr_sel;
  logic [7:0]       fn_sel;
  logic [31:0]      wdata_sel;
  logic [3:0]       be_sel;
  logic             wr_sel;

`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
`endif

  // First requester at or above the pointer wins; otherwise wrap to the lowest one.
  always_comb begin
    req      = s_cfg_mgmt_read | s_cfg_mgmt_write;
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_lo = PW'(i);
        if (PW'(i) >= ptr_q) begin
          pick_hi  = PW'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    addr_sel  = '0;
    fn_sel    = '0;
    wdata_sel = '0;
    be_sel    = '0;
    wr_sel    = 1'b0;
    gnt_oh    = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (PW'(i) == pick) begin
        addr_sel  = s_cfg_mgmt_addr[i*10 +: 10];
        fn_sel    = s_cfg_mgmt_function_number[i*8 +: 8];
        wdata_sel = s_cfg_mgmt_write_data[i*32 +: 32];
        be_sel    = s_cfg_mgmt_byte_enable[i*4 +: 4];
        wr_sel    = s_cfg_mgmt_write[i];
      end
      if (PW'(i) == grant_q) begin
        gnt_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    fn_d    = fn_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    done_d  = '0;
    tmo_d   = '0;
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          ptr_d   = (pick == PW'(PORTS - 1)) ? '0 : pick + PW'(1);
          addr_d  = addr_sel;
          fn_d    = fn_sel;
          wdata_d = wdata_sel;
          be_d    = be_sel;
          // A write wins when a port raises both levels.
          wr_d    = wr_sel;
          rd_d    = ~wr_sel;
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        if (cfg_mgmt_read_write_done) begin
          wr_d   = 1'b0;
          rd_d   = 1'b0;
          if (rd_q) begin
            rdata_d = cfg_mgmt_read_data;
          end
          done_d  = gnt_oh;
          state_d = GUARD;
        end
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          rdata_d = 32'hFFFF_FFFF;
          done_d  = gnt_oh;
          tmo_d   = gnt_oh;
          state_d = GUARD;
        end
`endif
      end
      // One dead cycle lets the completed requester drop its level.
      GUARD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      fn_q    <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      fn_q    <= fn_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign s_cfg_mgmt_timeout = tmo_q;
`else
  assign s_cfg_mgmt_timeout = '0;
`endif

  assign s_cfg_mgmt_read_data       = rdata_q;
  assign s_cfg_mgmt_read_write_done = done_q;
  assign cfg_mgmt_addr              = addr_q;
  assign cfg_mgmt_function_number   = fn_q;
  assign cfg_mgmt_write             = wr_q;
  assign cfg_mgmt_write_data        = wdata_q;
  assign cfg_mgmt_byte_enable       = be_q;
  assign cfg_mgmt_read              = rd_q;

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_arb.sv
// tb/tb_pcie_us_cfg_mgmt_arb.sv - scoreboard bench for pcie_us_cfg_mgmt_arb
// Timeout scenario follows PCIE_CFG_MGMT_ARB_TIMEOUT_EN.
module tb_pcie_us_cfg_mgmt_arb;
  localparam int PORTS = 2;
  localparam int TMO   = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [PORTS*10-1:0] s_addr;
  logic [PORTS*8-1:0]  s_fn;
  logic [PORTS-1:0]    s_write;
  logic [PORTS*32-1:0] s_wdata;
  logic [PORTS*4-1:0]  s_be;
  logic [PORTS-1:0]    s_read;
  logic [31:0]         s_rdata;
  logic [PORTS-1:0]    s_done;
  logic [PORTS-1:0]    s_timeout;
  logic [9:0]          c_addr;
  logic [7:0]          c_fn;
  logic                c_write;
  logic [31:0]         c_wdata;
  logic [3:0]          c_be;
  logic                c_read;
  logic [31:0]         c_rdata;
  logic                c_done;

  pcie_us_cfg_mgmt_arb #(.PORTS(PORTS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .s_cfg_mgmt_addr            (s_addr),
    .s_cfg_mgmt_function_number (s_fn),
    .s_cfg_mgmt_write           (s_write),
    .s_cfg_mgmt_write_data      (s_wdata),
    .s_cfg_mgmt_byte_enable     (s_be),
    .s_cfg_mgmt_read            (s_read),
    .s_cfg_mgmt_read_data       (s_rdata),
    .s_cfg_mgmt_read_write_done (s_done),
    .s_cfg_mgmt_timeout         (s_timeout),
    .cfg_mgmt_addr              (c_addr),
    .cfg_mgmt_function_number   (c_fn),
    .cfg_mgmt_write             (c_write),
    .cfg_mgmt_write_data        (c_wdata),
    .cfg_mgmt_byte_enable       (c_be),
    .cfg_mgmt_read              (c_read),
    .cfg_mgmt_read_data         (c_rdata),
    .cfg_mgmt_read_write_done   (c_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    bit          wr;
    logic [9:0]  addr;
    logic [7:0]  fn;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    bit          tmo;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_last = 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // IP model: answers done after ip_lat cycles of an asserted read/write.
  logic [31:0] ip_mem [1024];
  logic        ip_auto = 1'b0;
  logic        ip_force = 1'b0;
  logic        ip_mute = 1'b0;
  int          ip_lat = 5;
  int          ip_cnt = 0;
  logic [9:0]  seen_addr;
  logic [7:0]  seen_fn;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;
  logic        seen_wr, seen_rd;

  assign c_done  = ip_auto | ip_force;
  assign c_rdata = ip_auto ? ip_mem[c_addr] : 32'hDEAD_BEEF;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ip_auto = 1'b0;
      if (c_read || c_write) begin
        if (ip_cnt == 0) begin
          seen_addr  = c_addr;
          seen_fn    = c_fn;
          seen_be    = c_be;
          seen_wdata = c_wdata;
          seen_wr    = c_write;
          seen_rd    = c_read;
        end
        ip_cnt++;
        if (!ip_mute && ip_cnt == ip_lat) ip_auto = 1'b1;
      end else begin
        ip_cnt = 0;
      end
    end
  end

  // Completion monitor: pops the scoreboard and releases the requester's level.
  initial begin
    exp_t        e;
    logic [31:0] er;
    forever begin
      @(negedge clk);
      if (!rst && s_done != '0) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'(s_done), 64'd0);
        end else begin
          e  = sb.pop_front();
          er = e.tmo ? 32'hFFFF_FFFF : (e.wr ? model_last : e.rdata);
          check("done_vec", 64'(s_done), 64'(1 << e.port));
          check("tmo_vec", 64'(s_timeout), e.tmo ? 64'(1 << e.port) : 64'd0);
          check("rdata", 64'(s_rdata), 64'(er));
          check("ip_fields", 64'({seen_fn, seen_be, seen_addr}), 64'({e.fn, e.be, e.addr}));
          check("ip_op", 64'({seen_wr, seen_rd}), e.wr ? 64'd2 : 64'd1);
          if (e.wr) check("ip_wdata", 64'(seen_wdata), 64'(e.wdata));
          model_last = er;
          s_read[e.port]  = 1'b0;
          s_write[e.port] = 1'b0;
        end
      end else if (!rst && s_timeout != '0) begin
        check("stray_tmo", 64'(s_timeout), 64'd0);
      end
    end
  end

  task automatic issue(input int p, input bit wr, input bit rd, input logic [9:0] a,
                       input logic [31:0] wd, input bit tmo);
    exp_t e;
    e.port  = p;
    e.wr    = wr;
    e.addr  = a;
    e.fn    = a[7:0] ^ 8'hC3;
    e.wdata = wd;
    e.be    = ~a[3:0];
    e.rdata = ip_mem[a];
    e.tmo   = tmo;
    s_addr[p*10 +: 10]  = e.addr;
    s_fn[p*8 +: 8]      = e.fn;
    s_wdata[p*32 +: 32] = e.wdata;
    s_be[p*4 +: 4]      = e.be;
    s_write[p]          = wr;
    s_read[p]           = rd;
    sb.push_back(e);
  endtask

  task automatic wait_size(input string tag, input int n, input int bound);
    int k = 0;
    while (sb.size() != n && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, 64'(sb.size()), 64'(n));
  endtask

  task automatic wait_drain(input string tag, input int bound);
    wait_size(tag, 0, bound);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_read  = '0;
    s_write = '0;
    sb.delete();
    model_last = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int lat_tab[6] = '{1, 2, 7, 1, 4, 3};

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) ip_mem[i] = $urandom;
    ip_mem[4] = 32'h10EE_9038;
    s_addr = '0; s_fn = '0; s_wdata = '0; s_be = '0; s_read = '0; s_write = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cfg", 64'({c_read, c_write, c_addr, c_fn, c_be}), 64'd0);
    check("rst_wdata", 64'(c_wdata), 64'd0);
    check("rst_sout", 64'({s_done, s_timeout}), 64'd0);
    check("rst_rdata", 64'(s_rdata), 64'd0);
    @(posedge clk);
    #1;

    // Simultaneous writes from reset: grants 0,1,0,1
    ip_lat = 3;
    issue(0, 1'b1, 1'b0, 10'h020, 32'h1111_0000, 1'b0);
    issue(1, 1'b1, 1'b0, 10'h021, 32'h2222_0000, 1'b0);
    wait_size("rr_round1", 1, 100);
    issue(0, 1'b1, 1'b0, 10'h022, 32'h3333_0000, 1'b0);
    wait_size("rr_round2", 1, 100);
    issue(1, 1'b1, 1'b0, 10'h023, 32'h4444_0000, 1'b0);
    wait_drain("rr_drain", 100);

    // Port 1 read, 5-cycle IP latency
    ip_lat = 5;
    issue(1, 1'b0, 1'b1, 10'h004, 32'h0, 1'b0);
    @(negedge clk);
    check("t1_lat0", 64'(c_read), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_rd_hold", 64'(c_read), 64'd1);
    end
    @(negedge clk);
    check("t1_rd_drop", 64'(c_read), 64'd0);
    wait_drain("t1_drain", 50);
    check("t1_rdata", 64'(s_rdata), 64'h10EE_9038);

    // Read and write together: write wins, read data untouched
    issue(0, 1'b1, 1'b1, 10'h0A5, 32'hA5A5_A5A5, 1'b0);
    wait_drain("t3_drain", 50);
    check("t3_rdata_keep", 64'(s_rdata), 64'h10EE_9038);

    // Mixed accesses over several latencies, including 1
    for (int i = 0; i < 6; i++) begin
      ip_lat = lat_tab[i];
      issue(i % 2, ((i / 2) % 2) == 1, ((i / 2) % 2) == 0, 10'(40 + i * 13), $urandom, 1'b0);
      wait_drain("mix_drain", 50);
    end

    // Reset in the middle of an access, then a late done
    ip_lat = 20;
    issue(0, 1'b0, 1'b1, 10'h133, 32'h0, 1'b0);
    n = 0;
    while (!c_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_start", 64'(c_read), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    s_read = '0;
    s_write = '0;
    sb.delete();
    model_last = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t4_cfg_clr", 64'({c_read, c_write, c_addr, c_fn, c_be}), 64'd0);
    check("t4_wdata_clr", 64'(c_wdata), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ip_force = 1'b1;
    @(posedge clk); #1;
    ip_force = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_no_done", 64'(s_done), 64'd0);
    end
    @(posedge clk); #1;
    ip_lat = 2;
    issue(1, 1'b0, 1'b1, 10'h004, 32'h0, 1'b0);
    wait_drain("t4_after", 50);

    // Spurious done while idle
    ip_force = 1'b1;
    @(posedge clk); #1;
    ip_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur_quiet", 64'({s_done, s_timeout, c_read, c_write}), 64'd0);
      check("spur_rdata", 64'(s_rdata), 64'(model_last));
    end
    @(posedge clk); #1;

    // IP never answers
    ip_mute = 1'b1;
`ifdef PCIE_CFG_MGMT_ARB_TIMEOUT_EN
    issue(1, 1'b0, 1'b1, 10'h0F0, 32'h0, 1'b1);
    n = 0;
    while (!c_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (c_read && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("tmo_active_cycles", 64'(n), 64'(TMO));
    wait_drain("tmo_drain", 50);
    check("tmo_rdata", 64'(s_rdata), 64'hFFFF_FFFF);
`else
    issue(1, 1'b0, 1'b1, 10'h0F0, 32'h0, 1'b0);
    repeat (1100) @(negedge clk);
    check("notmo_active", 64'(c_read), 64'd1);
    check("notmo_pending", 64'(sb.size()), 64'd1);
    @(posedge clk); #1;
    do_reset();
`endif
    ip_mute = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach summary, applied %0d expected completion", n_vec);
    $fatal(1);
  end

endmodule
